ysyx_22050058_mem_arbiter: RTL

- Shares the single data-memory port between two requesters:
  - instruction fetch (IF), read-only;
  - load/store unit (LS), read or write.
- Sits between the pipeline and the memory block.
- Serialises accesses, one outstanding transaction at a time.
- Raises per-requester wait signals that feed the pipeline stall vector.

---
 rtl/ysyx_22050058_mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050058_mem_arbiter.sv
// Two-way data-memory arbiter: load/store has fixed priority over fetch, one transaction in flight.
// Optional response watchdog is compiled in when YSYX_22050058_ARB_TIMEOUT_EN is defined.
module ysyx_22050058_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int STRB_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_re_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_rvalid_o,
    output logic              if_wait_o,
    input  logic              ls_re_i,
    input  logic [STRB_W-1:0] ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_valid_o,
    output logic              ls_wait_o,
    output logic              err_o,
    output logic              memre_o,
    output logic [STRB_W-1:0] memwe_o,
    output logic [ADDR_W-1:0] memaddr_o,
    output logic [DATA_W-1:0] memwdata_o,
    input  logic [DATA_W-1:0] memrdata_i,
    input  logic              memrdatavaild_i,
    input  logic              memwdatavaild_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_memre;
    logic [STRB_W-1:0]   r_memwe;
    logic [ADDR_W-1:0]   r_memaddr;
    logic [DATA_W-1:0]   r_memwdata;
    logic                w_ls_req;
    logic                w_ls_wr;
    logic                w_busy_wr;
    logic                w_slave_done;
    logic                w_timeout;
    logic                w_done;

    assign w_ls_req  = ls_re_i | (|ls_we_i);
    assign w_ls_wr   = |ls_we_i;
    assign w_busy_wr = |r_memwe;

    // Only the valid matching the issued direction completes a transaction.
    always_comb begin
        w_slave_done = 1'b0;
        case (r_state)
            IF_BUSY: w_slave_done = memrdatavaild_i;
            LS_BUSY: w_slave_done = w_busy_wr ? memwdatavaild_i : memrdatavaild_i;
            default: w_slave_done = 1'b0;
        endcase
    end

`ifdef YSYX_22050058_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_wdog;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (r_state == IDLE) begin
            r_wdog <= '0;
        end else if (!w_slave_done) begin
            r_wdog <= r_wdog + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state != IDLE) && !w_slave_done && (r_wdog == CNT_W'(TIMEOUT));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    assign w_done = w_slave_done | w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_ls_req) begin
                    w_state_nxt = LS_BUSY;
                end else if (if_re_i) begin
                    w_state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory-side request is captured on the grant edge and held for the whole BUSY state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_memre    <= 1'b0;
            r_memwe    <= '0;
            r_memaddr  <= '0;
            r_memwdata <= '0;
        end else if (r_state == IDLE) begin
            if (w_ls_req) begin
                r_memre    <= ~w_ls_wr;
                r_memwe    <= ls_we_i;
                r_memaddr  <= ls_addr_i;
                r_memwdata <= w_ls_wr ? ls_wdata_i : '0;
            end else if (if_re_i) begin
                r_memre    <= 1'b1;
                r_memwe    <= '0;
                r_memaddr  <= if_addr_i;
                r_memwdata <= '0;
            end
        end else if (w_done) begin
            r_memre    <= 1'b0;
            r_memwe    <= '0;
            r_memaddr  <= '0;
            r_memwdata <= '0;
        end
    end

    always_comb begin
        if_rvalid_o = (r_state == IF_BUSY) && w_done;
        ls_valid_o  = (r_state == LS_BUSY) && w_done;
        if_rdata_o  = '0;
        ls_rdata_o  = '0;
        if ((r_state == IF_BUSY) && w_slave_done) begin
            if_rdata_o = memrdata_i;
        end
        if ((r_state == LS_BUSY) && w_slave_done && !w_busy_wr) begin
            ls_rdata_o = memrdata_i;
        end
    end

    assign err_o      = w_timeout;
    assign if_wait_o  = if_re_i & ~if_rvalid_o;
    assign ls_wait_o  = w_ls_req & ~ls_valid_o;
    assign memre_o    = r_memre;
    assign memwe_o    = r_memwe;
    assign memaddr_o  = r_memaddr;
    assign memwdata_o = r_memwdata;

endmodule
